collision_engine: RTL and testbench
===================================

// Module: collision_engine
// PURPOSE
//  Multi-object, frame-synchronous collision checker for the Dino Run game.
//  Compares the dino bounding box against NUM_OBJ obstacle/enemy boxes once per frame.
//  Tracks remaining lives with a post-hit invulnerability window, and drives is_alive to
//  the game-control and VGA layers.
//  Successor to the single-obstacle checker: adds N objects, lives, invulnerability and
//  registered outputs.
// PARAMETERS
//  COORD_W        10   width of every h/v pixel coordinate
//  NUM_OBJ        4    number of object slots checked per frame (1..8)
//  DINO_W         20   dino box width in pixels
//  DINO_H         20   dino box height in pixels
//  OBJ_W          16   object box width in pixels (all slots)
//  OBJ_H          16   object box height in pixels (all slots)
//  LIVES          3    lives loaded on start (1..7)
//  INVULN_FRAMES  60   frames of immunity after a non-fatal hit (>=1)
// PORTS
//  clk         in   1                  system clock
//  clr         in   1                  asynchronous, active-low reset
//  frame_tick  in   1                  1-cycle pulse per frame; only cycle a check occurs
//  start       in   1                  1-cycle pulse: begin/restart a run
//  dino_h      in   COORD_W            dino box left edge
//  dino_v      in   COORD_W            dino box top edge
//  obj_h       in   NUM_OBJ*COORD_W    packed left edges; slot i = [i*COORD_W +: COORD_W]
//  obj_v       in   NUM_OBJ*COORD_W    packed top edges, same packing
//  obj_valid   in   NUM_OBJ            slot i takes part in the check when 1
//  is_alive    out  1                  1 in ALIVE/INVULN
//  invuln      out  1                  1 in INVULN
//  lives_left  out  3                  remaining lives
//  hit         out  1                  1-cycle pulse when a life is lost
//  hit_mask    out  NUM_OBJ            slots overlapping at last counted hit; held until next hit/start
// BEHAVIOUR
//  Reset (clr=0, async): state=IDLE, is_alive=0, invuln=0, lives_left=0, hit=0,
//    hit_mask=0, frame counter=0. Reset mid-run aborts immediately; no pending hit survives.
//  Overlap, slot i:
//    (dino_h < oh+OBJ_W) && (oh < dino_h+DINO_W) && (dino_v < ov+OBJ_H) && (ov < dino_v+DINO_H)
//    Sums are computed at COORD_W+1 bits, so there is no wraparound at screen edge 1023.
//    Touching edges (equal) is NOT a hit. ovl[i] = overlap & obj_valid[i].
//  FSM states: IDLE, ALIVE, INVULN, DEAD. All outputs are registered.
//    Latency: 1 clk from the frame_tick or start sample to the output change.
//  IDLE/DEAD: start -> ALIVE, lives_left=LIVES, hit_mask=0. frame_tick is ignored.
//  ALIVE: frame_tick & |ovl ->
//    hit=1, hit_mask=ovl, lives_left-=1.
//    If the new lives_left is 0 -> DEAD (is_alive=0); otherwise -> INVULN with counter=INVULN_FRAMES.
//    Multiple overlapping slots in one frame cost exactly ONE life.
//  INVULN: each frame_tick decrements the counter. Overlaps are ignored.
//    When the counter reaches 0 on a tick -> ALIVE. Overlap on that same tick is NOT
//    counted; the first counted check is the next tick.
//  start in ALIVE/INVULN: restart (lives=LIVES, ALIVE, counter=0, hit_mask=0).
//    start wins over a simultaneous frame_tick.
//  hit is high for exactly one clk. hit never asserts outside a frame_tick-derived cycle.
//  Counter width = $clog2(INVULN_FRAMES+1). lives_left saturates at 0 and never underflows.
// STRUCTURE
//  Include file dino_defs.vh: state encodings (IDLE=0, ALIVE=1, INVULN=2, DEAD=3) and the
//    default COORD_W, shared with the renderer and game controller.
//  Sub-module aabb_overlap (parametrised on COORD_W and box sizes) is instantiated
//    NUM_OBJ times in a generate loop. The FSM and counters stay in collision_engine.
// TESTING
//  1 Reset then start: dino (0,320), slot0 (40,330) valid, tick -> no hit, is_alive=1, lives_left=3.
//  2 Slot0 moved to (19,330), tick -> hit pulse 1 clk after tick, lives_left=2, invuln=1, hit_mask=0001.
//    Slot0 at (20,330) (edge touch) instead -> no hit.
//  3 Continuous overlap with INVULN_FRAMES=60 -> next hit exactly 61 ticks after the first; lives 2->1.
//  4 Slots 0,2,3 overlap on one tick -> lives drop by 1 only, hit_mask=1101.
//    An overlapping slot with obj_valid=0 -> no hit.
//  5 Third hit -> lives_left=0, is_alive=0, DEAD. Further ticks -> no change.
//    start -> lives_left=3, is_alive=1.
//  6 Pull clr low mid-INVULN between clock edges -> outputs zero immediately.
//    start and tick in the same cycle -> restart only, no hit.
//    Object at h=1020 with dino at h=0 -> no wrap false hit.

Source files
------------

// File: rtl/collision_engine_pkg.sv
// -----------------------------------------------------------------------------
// collision_engine_pkg
//   Shared definitions for the Dino Run collision checker: FSM state encoding
//   (matches the renderer / game controller view: IDLE=0, ALIVE=1, INVULN=2,
//   DEAD=3), default coordinate width and the lives counter width.
// -----------------------------------------------------------------------------
package collision_engine_pkg;

    localparam int COORD_W_DEF = 10;
    localparam int LIVES_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALIVE  = 2'd1,
        ST_INVULN = 2'd2,
        ST_DEAD   = 2'd3
    } state_t;

endpackage : collision_engine_pkg

// File: rtl/collision_engine_aabb_overlap.sv
// -----------------------------------------------------------------------------
// aabb_overlap
//   Strict axis-aligned bounding-box overlap test between box A (the dino) and
//   box B (one object slot). Boxes that only touch edges do not overlap.
//   Ports:
//     a_h, a_v   in   COORD_W   box A left / top edge
//     b_h, b_v   in   COORD_W   box B left / top edge
//     overlap    out  1         1 when the interiors intersect
// -----------------------------------------------------------------------------
module aabb_overlap
    import collision_engine_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int A_W     = 20,
    parameter int A_H     = 20,
    parameter int B_W     = 16,
    parameter int B_H     = 16
) (
    input  logic [COORD_W-1:0] a_h,
    input  logic [COORD_W-1:0] a_v,
    input  logic [COORD_W-1:0] b_h,
    input  logic [COORD_W-1:0] b_v,
    output logic               overlap
);

    localparam int EW = COORD_W + 1;

    // One extra bit so a box near the far screen edge does not wrap its
    // right/bottom edge back to small coordinates.
    logic [EW-1:0] a_l, a_t, b_l, b_t;
    logic [EW-1:0] a_r, a_b, b_r, b_b;

    assign a_l = {1'b0, a_h};
    assign a_t = {1'b0, a_v};
    assign b_l = {1'b0, b_h};
    assign b_t = {1'b0, b_v};
    assign a_r = a_l + EW'(A_W);
    assign a_b = a_t + EW'(A_H);
    assign b_r = b_l + EW'(B_W);
    assign b_b = b_t + EW'(B_H);

    assign overlap = (a_l < b_r) && (b_l < a_r) && (a_t < b_b) && (b_t < a_b);

endmodule : aabb_overlap

// File: rtl/collision_engine.sv
// -----------------------------------------------------------------------------
// collision_engine
//   Frame-synchronous collision checker: compares the dino box against NUM_OBJ
//   object boxes on every frame_tick, tracks lives and a post-hit immunity
//   window, and reports liveness to the game-control / VGA layers. All outputs
//   are registered and change one clock after the sampled start / frame_tick.
//   Ports:
//     clk         in   1                 system clock
//     clr         in   1                 asynchronous active-low reset
//     frame_tick  in   1                 one-cycle pulse per frame
//     start       in   1                 one-cycle pulse: begin / restart a run
//     dino_h/v    in   COORD_W           dino box left / top edge
//     obj_h/v     in   NUM_OBJ*COORD_W   packed object left / top edges
//     obj_valid   in   NUM_OBJ           slot takes part in the check
//     is_alive    out  1                 run in progress (ALIVE or INVULN)
//     invuln      out  1                 immunity window active
//     lives_left  out  3                 remaining lives
//     hit         out  1                 one-cycle pulse when a life is lost
//     hit_mask    out  NUM_OBJ           slots overlapping at the last counted hit
// -----------------------------------------------------------------------------
module collision_engine
    import collision_engine_pkg::*;
#(
    parameter int COORD_W       = COORD_W_DEF,
    parameter int NUM_OBJ       = 4,
    parameter int DINO_W        = 20,
    parameter int DINO_H        = 20,
    parameter int OBJ_W         = 16,
    parameter int OBJ_H         = 16,
    parameter int LIVES         = 3,
    parameter int INVULN_FRAMES = 60
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       frame_tick,
    input  logic                       start,
    input  logic [COORD_W-1:0]         dino_h,
    input  logic [COORD_W-1:0]         dino_v,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_h,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_v,
    input  logic [NUM_OBJ-1:0]         obj_valid,
    output logic                       is_alive,
    output logic                       invuln,
    output logic [LIVES_W-1:0]         lives_left,
    output logic                       hit,
    output logic [NUM_OBJ-1:0]         hit_mask
);

    localparam int CNT_W = $clog2(INVULN_FRAMES + 1);

    // ---------------------------------------------------------------- overlap
    logic [NUM_OBJ-1:0] ovl_raw;
    logic [NUM_OBJ-1:0] ovl;

    for (genvar i = 0; i < NUM_OBJ; i++) begin : g_slot
        aabb_overlap #(
            .COORD_W (COORD_W),
            .A_W     (DINO_W),
            .A_H     (DINO_H),
            .B_W     (OBJ_W),
            .B_H     (OBJ_H)
        ) u_overlap (
            .a_h     (dino_h),
            .a_v     (dino_v),
            .b_h     (obj_h[i*COORD_W +: COORD_W]),
            .b_v     (obj_v[i*COORD_W +: COORD_W]),
            .overlap (ovl_raw[i])
        );
    end

    assign ovl = ovl_raw & obj_valid;

    // ------------------------------------------------------------------ state
    state_t               state_q, state_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_OBJ-1:0]   mask_q, mask_d;
    logic                 hit_q, hit_d;
    logic                 alive_q, alive_d;
    logic                 invuln_q, invuln_d;

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        hit_d   = 1'b0;

        if (start) begin
            // Restart from any state; beats a simultaneous frame_tick.
            state_d = ST_ALIVE;
            lives_d = LIVES_W'(LIVES);
            cnt_d   = '0;
            mask_d  = '0;
        end else begin
            unique case (state_q)
                ST_ALIVE: begin
                    if (frame_tick && (|ovl)) begin
                        // Any number of overlapping slots costs one life.
                        hit_d   = 1'b1;
                        mask_d  = ovl;
                        lives_d = (lives_q == '0) ? '0 : lives_q - 1'b1;
                        if (lives_q <= LIVES_W'(1)) begin
                            state_d = ST_DEAD;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_INVULN;
                            cnt_d   = CNT_W'(INVULN_FRAMES);
                        end
                    end
                end
                ST_INVULN: begin
                    // Overlaps are ignored here, including on the tick that
                    // ends the window.
                    if (frame_tick) begin
                        if (cnt_q <= CNT_W'(1)) begin
                            cnt_d   = '0;
                            state_d = ST_ALIVE;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                default: ; // IDLE / DEAD wait for start
            endcase
        end

        alive_d  = (state_d == ST_ALIVE) || (state_d == ST_INVULN);
        invuln_d = (state_d == ST_INVULN);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; the async clear aborts a run immediately.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= ST_IDLE;
            lives_q  <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            hit_q    <= 1'b0;
            alive_q  <= 1'b0;
            invuln_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lives_q  <= lives_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            hit_q    <= hit_d;
            alive_q  <= alive_d;
            invuln_q <= invuln_d;
        end
    end

    assign is_alive   = alive_q;
    assign invuln     = invuln_q;
    assign lives_left = lives_q;
    assign hit        = hit_q;
    assign hit_mask   = mask_q;

endmodule : collision_engine

// File: tb/tb_collision_engine.sv
// -----------------------------------------------------------------------------
// tb_collision_engine
//   Self-checking bench for collision_engine (default parameters). Directed
//   table vectors, hand-written multi-cycle sequences (immunity window, death,
//   asynchronous clear) and a randomized phase against a behavioural model.
//   Output vectors are compared as {hit, is_alive, invuln, lives_left, hit_mask}.
// -----------------------------------------------------------------------------
module tb_collision_engine;

    localparam int CW = 10;
    localparam int NO = 4;

    logic              clk = 1'b0;
    logic              clr;
    logic              frame_tick;
    logic              start;
    logic [CW-1:0]     dino_h, dino_v;
    logic [NO*CW-1:0]  obj_h, obj_v;
    logic [NO-1:0]     obj_valid;
    logic              is_alive, invuln, hit;
    logic [2:0]        lives_left;
    logic [NO-1:0]     hit_mask;

    always #5 clk = ~clk;

    collision_engine dut (
        .clk        (clk),
        .clr        (clr),
        .frame_tick (frame_tick),
        .start      (start),
        .dino_h     (dino_h),
        .dino_v     (dino_v),
        .obj_h      (obj_h),
        .obj_v      (obj_v),
        .obj_valid  (obj_valid),
        .is_alive   (is_alive),
        .invuln     (invuln),
        .lives_left (lives_left),
        .hit        (hit),
        .hit_mask   (hit_mask)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [9:0] expv(logic h, logic a, logic i, int l, logic [3:0] m);
        return {h, a, i, 3'(l), m};
    endfunction

    function automatic logic [9:0] dut_out();
        return {hit, is_alive, invuln, lives_left, hit_mask};
    endfunction

    function automatic logic [39:0] pack4(int a, int b, int c, int d);
        return {10'(d), 10'(c), 10'(b), 10'(a)};
    endfunction

    // ------------------------------------------------------ behavioural model
    // Game-level view: a run is idle, playing (possibly immune) or over.
    bit       m_running, m_over;
    int       m_lives, m_immune;
    bit       m_hit;
    bit [3:0] m_mask;

    task automatic model_reset();
        m_running = 0; m_over = 0; m_lives = 0; m_immune = 0; m_hit = 0; m_mask = 0;
    endtask

    function automatic bit boxes_touch(int dh, int dv, int oh, int ov);
        return (dh < oh + 16) && (oh < dh + 20) && (dv < ov + 16) && (ov < dv + 20);
    endfunction

    task automatic model_step(input logic st, input logic tk);
        bit [3:0] hits;
        m_hit = 0;
        if (st) begin
            m_running = 1; m_over = 0; m_lives = 3; m_immune = 0; m_mask = 0;
        end else if (tk && m_running) begin
            if (m_immune > 0) begin
                m_immune = m_immune - 1;
            end else begin
                hits = 0;
                for (int i = 0; i < NO; i++)
                    hits[i] = obj_valid[i] &&
                              boxes_touch(int'(dino_h), int'(dino_v),
                                          int'(obj_h[i*CW +: CW]), int'(obj_v[i*CW +: CW]));
                if (hits != 0) begin
                    m_hit   = 1;
                    m_mask  = hits;
                    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                    if (m_lives == 0) begin
                        m_running = 0; m_over = 1;
                    end else begin
                        m_immune = 60;
                    end
                end
            end
        end
    endtask

    function automatic logic [9:0] model_out();
        return expv(m_hit, m_running, m_running && (m_immune > 0), m_lives, m_mask);
    endfunction

    // Drive one cycle of inputs, clock it, advance the model, sample at +1.
    task automatic step(input logic st, input logic tk, input int dh, input int dv,
                        input logic [39:0] oh, input logic [39:0] ov, input logic [3:0] va);
        @(negedge clk);
        start = st; frame_tick = tk;
        dino_h = 10'(dh); dino_v = 10'(dv);
        obj_h = oh; obj_v = ov; obj_valid = va;
        @(posedge clk);
        model_step(st, tk);
        #1;
    endtask

    // ----------------------------------------------------------- vector table
    typedef struct {
        string       name;
        logic        st, tk;
        int          dh, dv;
        logic [39:0] oh, ov;
        logic [3:0]  va;
        logic [9:0]  exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string n, logic st, logic tk, int dh, int dv,
                                logic [39:0] oh, logic [39:0] ov, logic [3:0] va,
                                logic [9:0] e);
        vec_t v;
        v.name = n; v.st = st; v.tk = tk; v.dh = dh; v.dv = dv;
        v.oh = oh; v.ov = ov; v.va = va; v.exp = e;
        return v;
    endfunction

    initial begin
        logic [39:0] far_h, far_v, ovl_h, ovl_v;
        int ticks;

        far_h = pack4(500, 500, 500, 500);
        far_v = pack4(100, 100, 100, 100);
        ovl_h = pack4(19, 500, 500, 500);
        ovl_v = pack4(330, 100, 100, 100);

        tbl.push_back(mk("idle_tick",   0, 1, 0, 320, ovl_h, ovl_v, 4'b0001, expv(0,0,0,0,4'b0000)));
        tbl.push_back(mk("start",       1, 0, 0, 320, far_h, far_v, 4'b0000, expv(0,1,0,3,4'b0000)));
        tbl.push_back(mk("clear_tick",  0, 1, 0, 320, pack4(40,500,500,500), ovl_v, 4'b0001, expv(0,1,0,3,4'b0000)));
        tbl.push_back(mk("edge_touch",  0, 1, 0, 320, pack4(20,500,500,500), ovl_v, 4'b0001, expv(0,1,0,3,4'b0000)));
        tbl.push_back(mk("first_hit",   0, 1, 0, 320, ovl_h, ovl_v, 4'b0001, expv(1,1,1,2,4'b0001)));
        tbl.push_back(mk("hit_pulse1",  0, 0, 0, 320, ovl_h, ovl_v, 4'b0001, expv(0,1,1,2,4'b0001)));
        tbl.push_back(mk("restart",     1, 0, 0, 320, far_h, far_v, 4'b0000, expv(0,1,0,3,4'b0000)));
        tbl.push_back(mk("multi_hit",   0, 1, 0, 320, pack4(19,500,5,10), pack4(330,100,325,310), 4'b1111,
                         expv(1,1,1,2,4'b1101)));
        tbl.push_back(mk("restart2",    1, 0, 0, 320, far_h, far_v, 4'b0000, expv(0,1,0,3,4'b0000)));
        tbl.push_back(mk("invalid_ovl", 0, 1, 0, 320, ovl_h, ovl_v, 4'b1110, expv(0,1,0,3,4'b0000)));
        tbl.push_back(mk("start_tick",  1, 1, 0, 320, ovl_h, ovl_v, 4'b0001, expv(0,1,0,3,4'b0000)));
        tbl.push_back(mk("no_wrap",     0, 1, 0, 320, pack4(1020,500,500,500), pack4(320,100,100,100), 4'b0001,
                         expv(0,1,0,3,4'b0000)));
        tbl.push_back(mk("far_edge",    0, 1, 1010, 320, pack4(1015,500,500,500), pack4(320,100,100,100), 4'b0001,
                         expv(1,1,1,2,4'b0001)));

        // ------------------------------------------------------------ reset
        clr = 1'b0; start = 0; frame_tick = 0;
        dino_h = 0; dino_v = 0; obj_h = 0; obj_v = 0; obj_valid = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", 32'(dut_out()), 32'(expv(0,0,0,0,4'b0000)));
        @(negedge clk) clr = 1'b1;

        // ------------------------------------------------------ table phase
        foreach (tbl[k]) begin
            step(tbl[k].st, tbl[k].tk, tbl[k].dh, tbl[k].dv, tbl[k].oh, tbl[k].ov, tbl[k].va);
            check(tbl[k].name, 32'(dut_out()), 32'(tbl[k].exp));
        end

        // ------------------------- immunity window: next hit exactly 61 ticks
        ticks = 0;
        for (int k = 1; k <= 100; k++) begin
            step(0, 1, 0, 320, ovl_h, ovl_v, 4'b0001);
            if (k == 59) check("invuln_at_59", 32'(invuln), 32'd1);
            if (k == 60) check("alive_at_60", 32'({hit, invuln}), 32'd0);
            if (hit) begin ticks = k; break; end
        end
        check("second_hit_ticks", 32'(ticks), 32'd61);
        check("second_hit_out", 32'(dut_out()), 32'(expv(1,1,1,1,4'b0001)));

        // --------------------------------------------- third hit, dead state
        ticks = 0;
        for (int k = 1; k <= 100; k++) begin
            step(0, 1, 0, 320, ovl_h, ovl_v, 4'b0001);
            if (hit) begin ticks = k; break; end
        end
        check("third_hit_ticks", 32'(ticks), 32'd61);
        check("dead_out", 32'(dut_out()), 32'(expv(1,0,0,0,4'b0001)));
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, 320, pack4(19,5,10,0), pack4(330,325,310,320), 4'b1111);
            check("dead_ignores_tick", 32'(dut_out()), 32'(expv(0,0,0,0,4'b0001)));
        end
        step(1, 0, 0, 320, far_h, far_v, 4'b0000);
        check("revive", 32'(dut_out()), 32'(expv(0,1,0,3,4'b0000)));

        // ---------------------------------------- async clear mid-INVULN
        step(0, 1, 0, 320, ovl_h, ovl_v, 4'b0001);
        check("pre_clear_hit", 32'(dut_out()), 32'(expv(1,1,1,2,4'b0001)));
        #2 clr = 1'b0;
        #1 check("async_clear", 32'(dut_out()), 32'(expv(0,0,0,0,4'b0000)));
        model_reset();
        @(negedge clk) clr = 1'b1;
        step(0, 1, 0, 320, ovl_h, ovl_v, 4'b0001);
        check("post_clear_idle", 32'(dut_out()), 32'(expv(0,0,0,0,4'b0000)));

        // ------------------------------------------------- random phase
        for (int k = 0; k < 1500; k++) begin
            logic        st, tk;
            int          dh, dv;
            logic [39:0] oh, ov;
            st = ($urandom_range(0, 39) == 0);
            tk = ($urandom_range(0, 2) == 0);
            dh = int'($urandom_range(0, 1023));
            dv = int'($urandom_range(0, 1023));
            for (int i = 0; i < NO; i++) begin
                int x, y;
                if ($urandom_range(0, 1) == 0) begin
                    x = dh + int'($urandom_range(0, 44)) - 22;
                    y = dv + int'($urandom_range(0, 44)) - 22;
                    x = (x < 0) ? 0 : (x > 1023) ? 1023 : x;
                    y = (y < 0) ? 0 : (y > 1023) ? 1023 : y;
                end else begin
                    x = int'($urandom_range(0, 1023));
                    y = int'($urandom_range(0, 1023));
                end
                oh[i*CW +: CW] = 10'(x);
                ov[i*CW +: CW] = 10'(y);
            end
            step(st, tk, dh, dv, oh, ov, 4'($urandom_range(0, 15)));
            check("random", 32'(dut_out()), 32'(model_out()));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_collision_engine
